// File: rtl/ir_nec_pkg.sv
// Package: ir_nec_pkg
// Shared NEC infrared protocol definitions, used by the transmitter and by the
// receiver decoder.
//   - state encoding (4-bit codes)
//   - frame timing in NEC units (one unit is 562.5 us)
//   - helpers: is_mark() and nec_word()
package ir_nec_pkg;

  typedef logic [3:0] ir_state_t;

  localparam ir_state_t S_IDLE       = 4'd0;
  localparam ir_state_t S_LEAD_MARK  = 4'd1;
  localparam ir_state_t S_LEAD_SPACE = 4'd2;
  localparam ir_state_t S_BIT_MARK   = 4'd3;
  localparam ir_state_t S_BIT_SPACE  = 4'd4;
  localparam ir_state_t S_STOP_MARK  = 4'd5;
  localparam ir_state_t S_GAP        = 4'd6;
  localparam ir_state_t S_REP_MARK   = 4'd7;
  localparam ir_state_t S_REP_SPACE  = 4'd8;
  localparam ir_state_t S_REP_STOP   = 4'd9;
  localparam ir_state_t S_REP_GAP    = 4'd10;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int BIT_U        = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int REP_SPACE_U  = 4;
  localparam int NEC_BITS     = 32;

  // A mark is a state in which the carrier is emitted.
  function automatic logic is_mark(input ir_state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK) ||
           (s == S_REP_MARK)  || (s == S_REP_STOP);
  endfunction

  // Word on the wire, LSB first: address, ~address, command, ~command.
  function automatic logic [31:0] nec_word(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_nec_transmitter_carrier.sv
// Module: ir_carrier_gen
// Carrier generator with a 50% duty cycle. The carrier toggles every
// CARRIER_HALF clocks. A synchronous clear restarts the phase with carrier=1,
// so that each mark begins with the output high.
//   clk     in  system clock
//   reset   in  synchronous, active-high
//   clear   in  restart the phase; carrier is 1 after this edge
//   carrier out registered carrier square wave
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic carrier
);
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= '0;
      carrier <= 1'b0;
    end else if (clear) begin
      phase   <= '0;
      carrier <= 1'b1;
    end else if (phase == HALF_LAST) begin
      phase   <= '0;
      carrier <= ~carrier;
    end else begin
      phase <= phase + 1'b1;
    end
  end
endmodule

// File: rtl/ir_nec_transmitter.sv
// Module: ir_nec_transmitter
// NEC infrared transmitter. It sends one frame {~cmd, cmd, ~addr, addr},
// LSB first, with a modulated carrier on IRDA_TXD.
//   CLOCK_50    in   system clock
//   reset       in   synchronous, active-high
//   start       in   request; accepted only while busy=0
//   address     in   [7:0] latched on an accepted start
//   command     in   [7:0] latched on an accepted start
//   send_hold   in   (IR_REPEAT_EN only) keep sending repeat frames
//   busy        out  frame period in progress
//   done        out  one-cycle pulse on the last cycle of the final period
//   IRDA_TXD    out  ir_envelope & carrier
//   ir_envelope out  unmodulated mark envelope
//   state_dbg   out  [3:0] current FSM state
// Optional macro IR_REPEAT_EN adds NEC repeat frames driven by send_hold.
//
// Handshake: start is taken on a rising edge only when busy=0. The next cycle
// shows busy=1. While busy=1, start is ignored and nothing is queued. This
// includes the done cycle, because busy is still high then.
module ir_nec_transmitter
  import ir_nec_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int FRAME_UNITS  = 192
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] address,
  input  logic [7:0] command,
`ifdef IR_REPEAT_EN
  input  logic       send_hold,
`endif
  output logic       busy,
  output logic       done,
  output logic       IRDA_TXD,
  output logic       ir_envelope,
  output logic [3:0] state_dbg
);
  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0] UNIT_LAST  = UW'(UNIT_CYCLES - 1);
  localparam logic [7:0]    FRAME_LAST = 8'(FRAME_UNITS - 1);
  localparam logic [5:0]    LAST_BIT   = 6'(NEC_BITS - 1);

  ir_state_t     state, state_nx;
  logic [UW-1:0] unit_cnt;
  logic [4:0]    state_units;   // units already spent in the current state
  logic [7:0]    frame_units;   // units since the current period's leader
  logic [5:0]    bit_cnt;
  logic [31:0]   shreg;
  logic [4:0]    dur_last;
  logic          unit_last, seg_end, gap_end, adv, hold_req, carrier;

`ifdef IR_REPEAT_EN
  assign hold_req = send_hold;
`else
  assign hold_req = 1'b0;
`endif

  assign unit_last = (unit_cnt == UNIT_LAST);
  assign seg_end   = unit_last && (state_units == dur_last);
  // The gap length is not fixed. The gap ends when the whole period has elapsed.
  assign gap_end   = (state == S_GAP || state == S_REP_GAP) && unit_last &&
                     (frame_units == FRAME_LAST);
  assign done      = gap_end && !hold_req;
  assign state_dbg = state;
  assign IRDA_TXD  = ir_envelope & carrier;

  always_comb begin
    dur_last = 5'd0;
    case (state)
      S_LEAD_MARK:  dur_last = 5'(LEAD_MARK_U - 1);
      S_LEAD_SPACE: dur_last = 5'(LEAD_SPACE_U - 1);
      S_BIT_SPACE:  dur_last = shreg[0] ? 5'(ONE_SPACE_U - 1) : 5'(BIT_U - 1);
`ifdef IR_REPEAT_EN
      S_REP_MARK:   dur_last = 5'(LEAD_MARK_U - 1);
      S_REP_SPACE:  dur_last = 5'(REP_SPACE_U - 1);
`endif
      default:      dur_last = 5'(BIT_U - 1);
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (start)   state_nx = S_LEAD_MARK;
      S_LEAD_MARK:  if (seg_end) state_nx = S_LEAD_SPACE;
      S_LEAD_SPACE: if (seg_end) state_nx = S_BIT_MARK;
      S_BIT_MARK:   if (seg_end) state_nx = S_BIT_SPACE;
      S_BIT_SPACE:  if (seg_end) state_nx = (bit_cnt == LAST_BIT) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (seg_end) state_nx = S_GAP;
`ifdef IR_REPEAT_EN
      S_GAP:        if (gap_end) state_nx = hold_req ? S_REP_MARK : S_IDLE;
      S_REP_MARK:   if (seg_end) state_nx = S_REP_SPACE;
      S_REP_SPACE:  if (seg_end) state_nx = S_REP_STOP;
      S_REP_STOP:   if (seg_end) state_nx = S_REP_GAP;
      S_REP_GAP:    if (gap_end) state_nx = hold_req ? S_REP_MARK : S_IDLE;
`else
      S_GAP:        if (gap_end) state_nx = S_IDLE;
`endif
      default:      state_nx = S_IDLE;
    endcase
  end

  // Every transition out of a busy state changes the state code.
  assign adv = (state != S_IDLE) && (state_nx != state);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= S_IDLE;
      unit_cnt    <= '0;
      state_units <= '0;
      frame_units <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      busy        <= 1'b0;
      ir_envelope <= 1'b0;
    end else begin
      state       <= state_nx;
      ir_envelope <= is_mark(state_nx);
      if (state == S_IDLE) begin
        if (start) begin
          shreg       <= nec_word(address, command);
          bit_cnt     <= '0;
          unit_cnt    <= '0;
          state_units <= '0;
          frame_units <= '0;
          busy        <= 1'b1;
        end
      end else begin
        if (unit_last) begin
          unit_cnt    <= '0;
          state_units <= adv ? 5'd0 : state_units + 1'b1;
          // A repeat period measures its length from its own leader mark.
          frame_units <= (adv && state_nx == S_REP_MARK) ? 8'd0 : frame_units + 1'b1;
        end else begin
          unit_cnt <= unit_cnt + 1'b1;
        end
        if (adv && state == S_BIT_SPACE) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (adv && state_nx == S_IDLE) busy <= 1'b0;
      end
    end
  end

  // Restart the carrier phase on entry to each mark. Every mark follows a non-mark.
  ir_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
    .clk     (CLOCK_50),
    .reset   (reset),
    .clear   (is_mark(state_nx) && !is_mark(state)),
    .carrier (carrier)
  );

endmodule
